// File: rtl/gb_tb_pkg.sv
// Shared definitions for the Gaussian-blur stream harness:
// source FSM states, LFSR constants and default frame geometry.
package gb_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    // Taps x^8+x^6+x^5+x^4+1 map onto bits 7,5,4,3 of a left-shifting register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam int DEF_IMG_W = 648;
    localparam int DEF_IMG_H = 482;

    function automatic logic [7:0] lfsr8_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/gb_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous seed load and advance enable;
// shared by the stream source and the matching stream sink.
module gb_lfsr8
    import gb_tb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q
);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst)
            q <= LFSR_SEED;
        else if (load)
            q <= seed;
        else if (adv)
            q <= lfsr8_next(q);
    end

endmodule

// File: rtl/gb_stream_src.sv
// AXI-Stream frame source: emits IMG_W*IMG_H ramp or LFSR pixels per start,
// with optional idle gaps after each beat and TLAST on the final pixel.
module gb_stream_src
    import gb_tb_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = 8,
    parameter int GAP_W  = 4,
    parameter int CNT_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [GAP_W-1:0]  gap,
    output logic [DATA_W-1:0] arg_1_TDATA,
    output logic              arg_1_TVALID,
    input  logic              arg_1_TREADY,
    output logic              arg_1_TLAST,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pix_cnt
);

    localparam logic [CNT_W-1:0] TOTAL  = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);

    state_t             state;
    state_t             state_next;
    logic               mode_l;
    logic [GAP_W-1:0]   gap_l;
    logic [GAP_W-1:0]   gap_cnt;
    logic [CNT_W-1:0]   x;
    logic [CNT_W-1:0]   y;
    logic [7:0]         lfsr_q;
    logic               hs;
    logic               last_pix;
    logic               start_frame;

    assign hs          = (state == SEND) && arg_1_TREADY;
    assign last_pix    = (x == X_LAST) && (y == Y_LAST);
    assign start_frame = (state == IDLE) && start;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = SEND;
            SEND: begin
                if (hs) begin
                    if (last_pix)
                        state_next = DONE;
                    else if (gap_l != '0)
                        state_next = GAP;
                end
            end
            GAP:  if (gap_cnt == '0) state_next = SEND;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so TVALID never follows TREADY combinationally.
    always_comb begin
        arg_1_TVALID = (state == SEND);
        arg_1_TLAST  = (state == SEND) && last_pix;
        arg_1_TDATA  = mode_l ? DATA_W'(lfsr_q) : pix_cnt[DATA_W-1:0];
        busy         = (state != IDLE);
        done         = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_l  <= 1'b0;
            gap_l   <= '0;
            gap_cnt <= '0;
            x       <= '0;
            y       <= '0;
            pix_cnt <= '0;
        end else begin
            if (start_frame) begin
                mode_l  <= mode;
                gap_l   <= gap;
                x       <= '0;
                y       <= '0;
                pix_cnt <= '0;
            end
            if (hs) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
                if (pix_cnt != TOTAL)
                    pix_cnt <= pix_cnt + 1'b1;
                // Preloaded on every beat; only consumed when the FSM enters GAP.
                gap_cnt <= gap_l - 1'b1;
            end else if ((state == GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    gb_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_frame),
        .seed (LFSR_SEED),
        .adv  (hs),
        .q    (lfsr_q)
    );

endmodule

// File: tb/tb_gb_stream_src.sv
// Bench for gb_stream_src: three frame geometries (4x2, 1x1, 17x17) share
// one stimulus bus; a cycle table, corner sequences and random frames are checked.
module tb_gb_stream_src;

    localparam int ND = 3;
    localparam int NPIX [ND] = '{8, 1, 289};

    logic       clk;
    logic       rst;
    logic       start;
    logic       mode;
    logic [3:0] gap;
    logic       tready;

    logic [7:0]  tdata  [ND];
    logic        tvalid [ND];
    logic        tlast  [ND];
    logic        busy   [ND];
    logic        done   [ND];
    logic [18:0] pix    [ND];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] lfsr_ref [300];

    typedef struct {
        bit         start;
        bit         ready;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_last;
        bit         e_done;
        bit         e_busy;
        int         e_pix;
    } vec_t;

    gb_stream_src #(.IMG_W(4), .IMG_H(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .gap(gap),
        .arg_1_TDATA(tdata[0]), .arg_1_TVALID(tvalid[0]), .arg_1_TREADY(tready),
        .arg_1_TLAST(tlast[0]), .busy(busy[0]), .done(done[0]), .pix_cnt(pix[0])
    );

    gb_stream_src #(.IMG_W(1), .IMG_H(1)) dut_one (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .gap(gap),
        .arg_1_TDATA(tdata[1]), .arg_1_TVALID(tvalid[1]), .arg_1_TREADY(tready),
        .arg_1_TLAST(tlast[1]), .busy(busy[1]), .done(done[1]), .pix_cnt(pix[1])
    );

    gb_stream_src #(.IMG_W(17), .IMG_H(17)) dut_wrap (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .gap(gap),
        .arg_1_TDATA(tdata[2]), .arg_1_TVALID(tvalid[2]), .arg_1_TREADY(tready),
        .arg_1_TLAST(tlast[2]), .busy(busy[2]), .done(done[2]), .pix_cnt(pix[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference pattern from the polynomial's bit-stream recurrence:
    // b[n+8] = b[n] ^ b[n+2] ^ b[n+3] ^ b[n+4]; state k is b[k..k+7], MSB first.
    task automatic build_ref();
        bit b [308];
        for (int i = 0; i < 8; i++) b[i] = (i == 7);
        for (int n = 0; n < 300; n++) b[n+8] = b[n] ^ b[n+2] ^ b[n+3] ^ b[n+4];
        for (int k = 0; k < 300; k++)
            for (int j = 0; j < 8; j++) lfsr_ref[k][7-j] = b[k+j];
    endtask

    function automatic logic [7:0] exp_data(input int k, input bit m);
        return m ? lfsr_ref[k] : k[7:0];
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tready = 1'b0;
        tick();
        for (int d = 0; d < ND; d++) begin
            check("rst_valid", tvalid[d], 0);
            check("rst_last",  tlast[d],  0);
            check("rst_busy",  busy[d],   0);
            check("rst_done",  done[d],   0);
            check("rst_pix",   pix[d],    0);
            check("rst_data",  tdata[d],  0);
        end
        rst = 1'b0;
    endtask

    // Runs one frame on DUT d against the model: beat order, TLAST, gaps, stall stability, done.
    task automatic run_frame(input int d, input bit m, input int g, input int pct);
        int         n;
        int         k;
        int         idle;
        int         budget;
        bit         pv;
        bit         pl;
        logic [7:0] pd;
        n = NPIX[d]; k = 0; idle = 0;
        mode = m; gap = 4'(g); tready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check("first_valid", tvalid[d], 1);
        budget = 40 * n * (g + 1) + 100;
        while (k < n && budget > 0) begin
            budget--;
            pv = tvalid[d]; pd = tdata[d]; pl = tlast[d];
            tready = ($urandom_range(99) < pct);
            tick();
            if (pv && tready) begin
                check("beat_data", pd, exp_data(k, m));
                check("beat_last", pl, (k == n - 1));
                if (k > 0) check("gap_len", idle, g);
                idle = 0;
                k++;
                if (k < n) check("beat_pix", pix[d], k);
            end else if (pv) begin
                check("stall_valid", tvalid[d], 1);
                check("stall_data", tdata[d], pd);
            end
            if (!tvalid[d] && k < n) idle++;
        end
        check("frame_beats", k, n);
        check("end_done",  done[d],   1);
        check("end_valid", tvalid[d], 0);
        check("end_pix",   pix[d],    n);
        tready = 1'b0;
        tick();
        check("post_done", done[d], 0);
        check("post_busy", busy[d], 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [$];
        int   k;

        rst = 1'b1; start = 1'b0; mode = 1'b0; gap = '0; tready = 1'b0;
        build_ref();

        // Cycle-exact table on the 4x2 ramp frame, including start in DONE and while busy.
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 0});
        for (int b = 1; b < 8; b++)
            tbl.push_back('{1'b0, 1'b1, 1'b1, 8'(b), (b == 7), 1'b0, 1'b1, b});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 0});
        tbl.push_back('{1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1});

        do_reset();
        mode = 1'b0; gap = '0;
        foreach (tbl[i]) begin
            start = tbl[i].start; tready = tbl[i].ready;
            tick();
            check("tbl_valid", tvalid[0], tbl[i].e_valid);
            if (tbl[i].e_valid) begin
                check("tbl_data", tdata[0], tbl[i].e_data);
                check("tbl_last", tlast[0], tbl[i].e_last);
            end
            check("tbl_done", done[0], tbl[i].e_done);
            check("tbl_busy", busy[0], tbl[i].e_busy);
            check("tbl_pix",  pix[0],  tbl[i].e_pix);
        end
        start = 1'b0;

        // Five-cycle stall on beat 3: data held, nothing dropped or repeated.
        do_reset();
        mode = 1'b0; gap = '0; tready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("pre_stall_data", tdata[0], 3);
        tready = 1'b0;
        repeat (5) begin
            tick();
            check("stall_hold_valid", tvalid[0], 1);
            check("stall_hold_data",  tdata[0],  3);
        end
        tready = 1'b1;
        k = 3;
        for (int c = 0; c < 20 && !done[0]; c++) begin
            if (tvalid[0]) begin
                check("resume_data", tdata[0], k);
                k++;
            end
            tick();
        end
        check("stall_total", k, 8);
        check("stall_done", done[0], 1);

        // Reset mid-frame while beat 5 is pending, then a clean restart.
        do_reset();
        mode = 1'b0; gap = '0; tready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("abort_beat", tdata[0], 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", tvalid[0], 0);
        check("abort_busy",  busy[0],   0);
        check("abort_pix",   pix[0],    0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_valid", tvalid[0], 1);
        check("restart_data",  tdata[0],  0);

        // Directed frames: LFSR with gap 2, single-pixel frame, ramp wrap past 255.
        do_reset();
        run_frame(0, 1'b1, 2, 100);
        do_reset();
        run_frame(1, 1'b0, 0, 100);
        do_reset();
        run_frame(2, 1'b0, 0, 100);

        // Randomized frames with random mode, gap and backpressure.
        for (int it = 0; it < 8; it++) begin
            do_reset();
            run_frame(it % ND, 1'($urandom_range(1)), int'($urandom_range(3)),
                      int'($urandom_range(100, 50)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
